// File: rtl/bus_arbiter_wb8.sv
// Two-master Wishbone arbiter with an 8-bit data path, round-robin tie break,
// a single outstanding transfer and a watchdog that force-completes a silent slave.
module bus_arbiter_wb8 #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADRBITS        = 32
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [1:0]             M_CYC_I,
    input  logic [1:0]             M_STB_I,
    input  logic [1:0]             M_WE_I,
    input  logic [2*ADRBITS-1:0]   M_ADR_I,
    input  logic [15:0]            M_DAT_I,
    output logic [7:0]             M_DAT_O,
    output logic [1:0]             M_ACK_O,
    output logic [1:0]             M_STALL_O,
    output logic                   S_CYC_O,
    output logic                   S_STB_O,
    output logic                   S_WE_O,
    output logic [ADRBITS-1:0]     S_ADR_O,
    output logic [7:0]             S_DAT_O,
    input  logic [7:0]             S_DAT_I,
    input  logic                   S_ACK_I,
    input  logic                   S_STALL_I,
    output logic [1:0]             O_owner,
    output logic                   O_timeout
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // State encoding doubles as the one-hot owner vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t           state;
    logic             last_owner;
    logic             pending;
    logic [CNT_W-1:0] cnt;

    logic busy;
    logic own;
    logic own_cyc;
    logic timeout_hit;
    logic ack_own;

    assign busy        = (state == OWN0) || (state == OWN1);
    assign own         = (state == OWN1);
    assign own_cyc     = busy & M_CYC_I[own];
    assign timeout_hit = own_cyc & pending & ~S_ACK_I & (cnt == TO_LAST);
    assign ack_own     = own_cyc & ((pending & S_ACK_I) | timeout_hit);
    assign O_owner     = state;
    assign O_timeout   = timeout_hit;

    // Shared-bus mux and per-master handshake returns.
    always_comb begin
        S_CYC_O   = 1'b0;
        S_STB_O   = 1'b0;
        S_WE_O    = 1'b0;
        S_ADR_O   = '0;
        S_DAT_O   = 8'h00;
        M_ACK_O   = 2'b00;
        M_STALL_O = M_CYC_I;
        M_DAT_O   = timeout_hit ? 8'hFF : S_DAT_I;
        if (busy) begin
            S_CYC_O          = own_cyc;
            S_STB_O          = own_cyc & M_STB_I[own] & ~pending;
            S_WE_O           = M_WE_I[own];
            S_ADR_O          = own ? M_ADR_I[ADRBITS +: ADRBITS] : M_ADR_I[ADRBITS-1:0];
            S_DAT_O          = own ? M_DAT_I[15:8] : M_DAT_I[7:0];
            M_STALL_O[own]   = S_STALL_I | pending;
            M_ACK_O[own]     = ack_own;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            pending    <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pending <= 1'b0;
                    cnt     <= '0;
                    case (M_CYC_I)
                        2'b01:   state <= OWN0;
                        2'b10:   state <= OWN1;
                        2'b11:   state <= last_owner ? OWN0 : OWN1;
                        default: state <= IDLE;
                    endcase
                end
                OWN0, OWN1: begin
                    if (!own_cyc) begin
                        // Release abandons any outstanding transfer.
                        state      <= IDLE;
                        last_owner <= own;
                        pending    <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        if (pending && (S_ACK_I || timeout_hit))
                            pending <= 1'b0;
                        else if (S_STB_O && !S_STALL_I)
                            pending <= 1'b1;
                        if (!pending || S_ACK_I)
                            cnt <= '0;
                        else
                            cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
